// File: rtl/audio_playback_fifo_if.sv
// Producer-side write channel of the playback FIFO: one stereo frame per valid/ready handshake.
interface audio_playback_fifo_if #(
  parameter int DATA_W = 16
);
  logic                     wr_valid;
  logic                     wr_ready;
  logic signed [DATA_W-1:0] wr_left;
  logic signed [DATA_W-1:0] wr_right;

  modport master (output wr_valid, output wr_left, output wr_right, input wr_ready);
  modport slave  (input wr_valid, input wr_left, input wr_right, output wr_ready);
endinterface

// File: rtl/audio_playback_fifo.sv
// Stereo playback buffer feeding the codec serializer: frames pushed by a producer,
// popped on the left-channel sample request, underruns replaced by silence and counted.
module audio_playback_fifo #(
  parameter int DEPTH     = 64,
  parameter int AW        = 6,
  parameter int LOW_WATER = 16,
  parameter int DATA_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  audio_playback_fifo_if.slave     wr_if,
  input  logic [1:0]               sample_req,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     clear_underrun,
  output logic signed [DATA_W-1:0] audio_output_l,
  output logic signed [DATA_W-1:0] audio_output_r,
  output logic [AW:0]              level,
  output logic                     need_data,
  output logic [15:0]              underrun_count
);

  localparam int          W2       = 2 * DATA_W;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LOW_LVL  = (AW+1)'(LOW_WATER);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W2-1:0]            mem_q [DEPTH];
  logic [AW-1:0]            wptr_q, wptr_d;
  logic [AW-1:0]            rptr_q, rptr_d;
  logic [AW:0]              level_q, level_d;
  logic signed [DATA_W-1:0] out_l_q, out_l_d;
  logic signed [DATA_W-1:0] out_r_q, out_r_d;
  logic [15:0]              urun_q, urun_d;
  logic                     need_q, need_d;

  logic          full, empty;
  logic          wr_ready_c, wr_fire;
  logic          pop_evt, pop_ok;
  logic [W2-1:0] rd_word;
  logic          unused_right_req;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // The right-channel request needs no action: its sample was latched with the left pop.
  assign unused_right_req = sample_req[0];

  assign full       = (level_q == FULL_LVL);
  assign empty      = (level_q == '0);
  assign wr_ready_c = !full && !flush;
  assign wr_fire    = wr_if.wr_valid && wr_ready_c;
  assign pop_evt    = sample_req[1] && enable;
  assign pop_ok     = pop_evt && !empty;
  assign rd_word    = mem_q[rptr_q];

  assign wr_if.wr_ready = wr_ready_c;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wptr_q] <= {wr_if.wr_left, wr_if.wr_right};
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    out_l_d = out_l_q;
    out_r_d = out_r_q;
    urun_d  = urun_q;

    // A disabled or empty request plays silence; no request holds the last sample.
    if (sample_req[1]) begin
      if (pop_ok) begin
        out_l_d = $signed(rd_word[W2-1:DATA_W]);
        out_r_d = $signed(rd_word[DATA_W-1:0]);
      end else begin
        out_l_d = '0;
        out_r_d = '0;
      end
    end

    if (clear_underrun) begin
      urun_d = '0;
    end else if (pop_evt && empty) begin
      urun_d = sat_inc16(urun_q);
    end

    // Flush wins over pop and write for the pointers; a coincident pop still plays out.
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_fire) wptr_d = wptr_q + PTR_ONE;
      if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
      case ({wr_fire, pop_ok})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end

    need_d = (level_d <= LOW_LVL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      out_l_q <= '0;
      out_r_q <= '0;
      urun_q  <= '0;
      need_q  <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      out_l_q <= out_l_d;
      out_r_q <= out_r_d;
      urun_q  <= urun_d;
      need_q  <= need_d;
    end
  end

  assign audio_output_l = out_l_q;
  assign audio_output_r = out_r_q;
  assign level          = level_q;
  assign need_data      = need_q;
  assign underrun_count = urun_q;

endmodule

// File: tb/tb_audio_playback_fifo.sv
// Bench for audio_playback_fifo: queue-based frame model checked every cycle plus directed literals.
module tb_audio_playback_fifo;
  localparam int DEPTH = 64;
  localparam int LOW_WATER = 16;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] sample_req;
  logic enable, flush, clear_underrun;
  logic signed [15:0] audio_output_l, audio_output_r;
  logic [6:0] level;
  logic need_data;
  logic [15:0] underrun_count;

  int n_vec = 0;
  int n_bad = 0;

  audio_playback_fifo_if #(.DATA_W(16)) wr_if ();

  audio_playback_fifo #(.DEPTH(DEPTH), .AW(6), .LOW_WATER(LOW_WATER), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .wr_if(wr_if), .sample_req(sample_req), .enable(enable),
    .flush(flush), .clear_underrun(clear_underrun), .audio_output_l(audio_output_l),
    .audio_output_r(audio_output_r), .level(level), .need_data(need_data),
    .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  // Model: a queue of frames, with outputs, counter and flag derived from the rules directly.
  logic [31:0] q[$];
  logic [15:0] m_l = '0, m_r = '0, m_uc = '0;
  logic m_need = 1'b1;
  logic m_wr, m_pop, m_empty;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_l = '0; m_r = '0; m_uc = '0; m_need = 1'b1;
    end else begin
      m_empty = (q.size() == 0);
      m_wr    = wr_if.wr_valid && (q.size() < DEPTH) && !flush;
      m_pop   = sample_req[1] && enable;
      if (sample_req[1]) begin
        if (m_pop && !m_empty) begin m_l = q[0][31:16]; m_r = q[0][15:0]; end
        else begin m_l = '0; m_r = '0; end
      end
      if (clear_underrun) m_uc = '0;
      else if (m_pop && m_empty && m_uc != 16'hFFFF) m_uc = m_uc + 16'd1;
      if (flush) q.delete();
      else begin
        if (m_pop && !m_empty) void'(q.pop_front());
        if (m_wr) q.push_back({wr_if.wr_left, wr_if.wr_right});
      end
      m_need = (q.size() <= LOW_WATER);
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_out_l", audio_output_l, m_l);
    chk("model_out_r", audio_output_r, m_r);
    chk("model_level", {9'd0, level}, 16'(q.size()));
    chk("model_need", {15'd0, need_data}, {15'd0, m_need});
    chk("model_underrun", underrun_count, m_uc);
    chk("model_wr_ready", {15'd0, wr_if.wr_ready},
        {15'd0, (q.size() < DEPTH) && !flush});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse();
    sample_req = 2'b10;
    tick();
    sample_req = 2'b00;
  endtask

  task automatic write1(input logic [15:0] l, input logic [15:0] r);
    wr_if.wr_valid = 1'b1; wr_if.wr_left = l; wr_if.wr_right = r;
    tick();
    wr_if.wr_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] e;
    reset = 1'b1; sample_req = 2'b00; enable = 1'b1; flush = 1'b0; clear_underrun = 1'b0;
    wr_if.wr_valid = 1'b0; wr_if.wr_left = '0; wr_if.wr_right = '0;
    idle(3);
    chk("rst_level", {9'd0, level}, 16'd0);
    chk("rst_need", {15'd0, need_data}, 16'd1);
    chk("rst_out_l", audio_output_l, 16'h0000);
    reset = 1'b0;
    #1;
    chk("wr_ready_after_rst", {15'd0, wr_if.wr_ready}, 16'd1);
    tick();

    // Two frames, two widely spaced pops
    write1(16'h1111, 16'h2222);
    write1(16'h3333, 16'h4444);
    chk("t1_level2", {9'd0, level}, 16'd2);
    pulse();
    chk("t1_p1_l", audio_output_l, 16'h1111);
    chk("t1_p1_r", audio_output_r, 16'h2222);
    chk("t1_level1", {9'd0, level}, 16'd1);
    idle(127);
    pulse();
    chk("t1_p2_l", audio_output_l, 16'h3333);
    chk("t1_p2_r", audio_output_r, 16'h4444);
    chk("t1_level0", {9'd0, level}, 16'd0);
    chk("t1_uc", underrun_count, 16'd0);

    // Fill to capacity (pointers start at 2, so draining wraps them)
    wr_if.wr_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      wr_if.wr_left = 16'(i); wr_if.wr_right = ~16'(i);
      tick();
    end
    chk("fill_level64", {9'd0, level}, 16'd64);
    chk("fill_ready0", {15'd0, wr_if.wr_ready}, 16'd0);
    wr_if.wr_left = 16'h0040; wr_if.wr_right = 16'hFFBF;
    idle(2);
    chk("fill_65th_rejected", {9'd0, level}, 16'd64);
    wr_if.wr_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      pulse();
      e = 16'(i);
      chk("drain_l", audio_output_l, e);
      e = ~16'(i);
      chk("drain_r", audio_output_r, e);
      idle(2);
    end
    chk("drain_level0", {9'd0, level}, 16'd0);

    // Underruns, then clear against a coincident underrun
    for (int i = 0; i < 3; i++) begin pulse(); idle(2); end
    chk("ur_out_l", audio_output_l, 16'h0000);
    chk("ur_out_r", audio_output_r, 16'h0000);
    chk("ur_count3", underrun_count, 16'd3);
    sample_req = 2'b10; clear_underrun = 1'b1;
    tick();
    sample_req = 2'b00; clear_underrun = 1'b0;
    chk("ur_clear_wins", underrun_count, 16'd0);

    // Write coincident with pop on empty: no bypass
    wr_if.wr_valid = 1'b1; wr_if.wr_left = 16'h7FFF; wr_if.wr_right = 16'h8000;
    sample_req = 2'b10;
    tick();
    wr_if.wr_valid = 1'b0; sample_req = 2'b00;
    chk("nobypass_uc", underrun_count, 16'd1);
    chk("nobypass_out_l", audio_output_l, 16'h0000);
    chk("nobypass_level", {9'd0, level}, 16'd1);
    idle(2);
    pulse();
    chk("nobypass_next_l", audio_output_l, 16'h7FFF);
    chk("nobypass_next_r", audio_output_r, 16'h8000);

    // Low-water threshold, then flush
    wr_if.wr_valid = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      wr_if.wr_left = 16'(k); wr_if.wr_right = 16'(k + 100);
      tick();
      if (k == 16) chk("need_at_16", {15'd0, need_data}, 16'd1);
      if (k == 17) chk("need_at_17", {15'd0, need_data}, 16'd0);
    end
    wr_if.wr_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_level", {9'd0, level}, 16'd0);
    chk("flush_need", {15'd0, need_data}, 16'd1);
    chk("flush_out_l_kept", audio_output_l, 16'h7FFF);
    pulse();
    chk("flush_then_ur", underrun_count, 16'd2);

    // Flush with coincident pop and write: pop plays, write dropped
    for (int k = 0; k < 3; k++) write1(16'h0A00 + 16'(k), 16'h0B00 + 16'(k));
    flush = 1'b1; sample_req = 2'b10;
    wr_if.wr_valid = 1'b1; wr_if.wr_left = 16'h0EEE; wr_if.wr_right = 16'h0FFF;
    tick();
    flush = 1'b0; sample_req = 2'b00; wr_if.wr_valid = 1'b0;
    chk("flushpop_l", audio_output_l, 16'h0A00);
    chk("flushpop_level", {9'd0, level}, 16'd0);

    // Right request is a no-op; disabled request plays silence without popping
    for (int k = 0; k < 6; k++) write1(16'h0C00 + 16'(k), 16'h0D00 + 16'(k));
    pulse();
    chk("en_pop_r", audio_output_r, 16'h0D00);
    sample_req = 2'b01;
    tick();
    sample_req = 2'b00;
    chk("rreq_hold_l", audio_output_l, 16'h0C00);
    chk("rreq_level", {9'd0, level}, 16'd5);
    enable = 1'b0;
    pulse();
    enable = 1'b1;
    chk("dis_out_l", audio_output_l, 16'h0000);
    chk("dis_out_r", audio_output_r, 16'h0000);
    chk("dis_level", {9'd0, level}, 16'd5);
    chk("dis_uc", underrun_count, 16'd2);
    idle(2);
    pulse();
    chk("en_resume_l", audio_output_l, 16'h0C01);

    // Asynchronous reset in the middle of a write burst
    wr_if.wr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_if.wr_left = 16'h5000 + 16'(k); wr_if.wr_right = 16'h6000 + 16'(k);
      tick();
    end
    #2 reset = 1'b1;
    #1;
    chk("arst_out_l", audio_output_l, 16'h0000);
    chk("arst_out_r", audio_output_r, 16'h0000);
    chk("arst_level", {9'd0, level}, 16'd0);
    chk("arst_uc", underrun_count, 16'd0);
    chk("arst_need", {15'd0, need_data}, 16'd1);
    idle(2);
    wr_if.wr_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("post_rst_level", {9'd0, level}, 16'd0);
    write1(16'h1234, 16'h5678);
    pulse();
    chk("post_rst_l", audio_output_l, 16'h1234);
    chk("post_rst_r", audio_output_r, 16'h5678);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
